// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// Holds opcodes, FSM state codes, ALU/mux select codes and the packed control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Code 4'd15 is unused; the FSM treats it as a recovery path to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ANDIEX  = 4'd11,
        S_IMMWB   = 4'd12,
        S_JEX     = 4'd13,
        S_TRAP    = 4'd14
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic       branch;
        logic       branch_ne;
        logic       illegal;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
    } ctrl_word_t;

endpackage

// File: rtl/mc_maindec_if.sv
// Controller <-> datapath bundle: opcode and memory-ready in, control enables and selects out.
// master = controller side, slave = datapath side.
interface mc_maindec_if #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2
);
    logic [OP_W-1:0]    op;
    logic               mem_ready;
    logic               pcwrite;
    logic               irwrite;
    logic               regwrite;
    logic               memwrite;
    logic               iord;
    logic               memtoreg;
    logic               regdst;
    logic               alusrca;
    logic               branch;
    logic               branch_ne;
    logic [1:0]         alusrcb;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic               illegal;

    modport master (
        input  op, mem_ready,
        output pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
               alusrca, branch, branch_ne, alusrcb, pcsrc, aluop, illegal
    );

    modport slave (
        output op, mem_ready,
        input  pcwrite, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
               alusrca, branch, branch_ne, alusrcb, pcsrc, aluop, illegal
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control word decode; zero latency, no handshake of its own.
// FETCH's pcwrite/irwrite here are raw and are qualified by mem_ready in the parent.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    output ctrl_word_t o_cw,
    output logic [1:0] o_aluop
);

    always_comb begin
        o_cw    = '0;
        o_aluop = ALUOP_ADD;
        case (i_state)
            S_FETCH: begin
                o_cw.alusrcb = SRCB_FOUR;
                o_cw.pcsrc   = PCSRC_ALU;
                o_cw.irwrite = 1'b1;
                o_cw.pcwrite = 1'b1;
            end
            S_DECODE: begin
                o_cw.alusrcb = SRCB_IMMSH;
            end
            S_MEMADR: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                o_cw.iord = 1'b1;
            end
            S_MEMWB: begin
                o_cw.memtoreg = 1'b1;
                o_cw.regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_cw.iord     = 1'b1;
                o_cw.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_B;
                o_aluop      = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                o_cw.regdst   = 1'b1;
                o_cw.regwrite = 1'b1;
            end
            S_BEQEX: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_B;
                o_cw.pcsrc   = PCSRC_ALUOUT;
                o_cw.branch  = 1'b1;
                o_aluop      = ALUOP_SUB;
            end
            S_BNEEX: begin
                o_cw.alusrca   = 1'b1;
                o_cw.alusrcb   = SRCB_B;
                o_cw.pcsrc     = PCSRC_ALUOUT;
                o_cw.branch_ne = 1'b1;
                o_aluop        = ALUOP_SUB;
            end
            S_ADDIEX: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_IMM;
            end
            S_ANDIEX: begin
                o_cw.alusrca = 1'b1;
                o_cw.alusrcb = SRCB_IMM;
                o_aluop      = ALUOP_AND;
            end
            S_IMMWB: begin
                o_cw.regwrite = 1'b1;
            end
            S_JEX: begin
                o_cw.pcsrc   = PCSRC_JUMP;
                o_cw.pcwrite = 1'b1;
            end
            S_TRAP: begin
                o_cw.illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: Moore FSM, 3-5 cycles per instruction.
// mem_ready low stalls FETCH, MEMRD and MEMWR one cycle at a time; reset blanks all write enables.
module mc_maindec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter bit EN_BNE  = 1'b1,
    parameter bit EN_ANDI = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    mc_maindec_if.master bus
);

    state_t          r_state;
    state_t          w_next;
    logic [OP_W-1:0] r_op;
    ctrl_word_t      w_cw;
    logic [1:0]      w_aluop;
    logic            w_fetch_ok;
    logic            w_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // MEMADR needs to know LW vs SW after op has moved on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= '0;
        end else if (r_state == S_DECODE) begin
            r_op <= bus.op;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_BNE:       w_next = EN_BNE ? S_BNEEX : S_TRAP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_ANDI:      w_next = EN_ANDI ? S_ANDIEX : S_TRAP;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (r_op == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (r_op == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMRD:   w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_RTYPEWB: w_next = S_FETCH;
            S_BEQEX:   w_next = S_FETCH;
            S_BNEEX:   w_next = S_FETCH;
            S_ADDIEX:  w_next = S_IMMWB;
            S_ANDIEX:  w_next = S_IMMWB;
            S_IMMWB:   w_next = S_FETCH;
            S_JEX:     w_next = S_FETCH;
            S_TRAP:    w_next = S_FETCH;
            default:   w_next = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .i_state (r_state),
        .o_cw    (w_cw),
        .o_aluop (w_aluop)
    );

    // Write enables are forced low combinationally so an async reset kills them mid-cycle.
    assign w_run      = ~reset;
    assign w_fetch_ok = (r_state == S_FETCH) ? bus.mem_ready : 1'b1;

    assign bus.pcwrite   = w_run & w_cw.pcwrite & w_fetch_ok;
    assign bus.irwrite   = w_run & w_cw.irwrite & w_fetch_ok;
    assign bus.regwrite  = w_run & w_cw.regwrite;
    assign bus.memwrite  = w_run & w_cw.memwrite;
    assign bus.branch    = w_run & w_cw.branch;
    assign bus.branch_ne = w_run & w_cw.branch_ne;
    assign bus.illegal   = w_run & w_cw.illegal;
    assign bus.iord      = w_cw.iord;
    assign bus.memtoreg  = w_cw.memtoreg;
    assign bus.regdst    = w_cw.regdst;
    assign bus.alusrca   = w_cw.alusrca;
    assign bus.alusrcb   = w_cw.alusrcb;
    assign bus.pcsrc     = w_cw.pcsrc;
    assign bus.aluop     = ALUOP_W'(w_aluop);

endmodule

// File: tb/tb_mc_maindec.sv
// Bench for mc_maindec: per-instruction expected cycle schedule built from the opcode rules.
// Two DUTs share stimulus: one with BNE/ANDI enabled, one with both disabled.
`timescale 1ns/1ps
module tb_mc_maindec;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] drv_op;
    logic       drv_mr;
    logic       sel;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    mc_maindec_if #(.OP_W(6), .ALUOP_W(2)) bus0 ();
    mc_maindec_if #(.OP_W(6), .ALUOP_W(2)) bus1 ();

    assign bus0.op        = drv_op;
    assign bus0.mem_ready = drv_mr;
    assign bus1.op        = drv_op;
    assign bus1.mem_ready = drv_mr;

    mc_maindec #(.OP_W(6), .ALUOP_W(2), .EN_BNE(1'b1), .EN_ANDI(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
    mc_maindec #(.OP_W(6), .ALUOP_W(2), .EN_BNE(1'b0), .EN_ANDI(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));

    // Enable vector: {pcwrite, irwrite, regwrite, memwrite, branch, branch_ne, illegal, iord, memtoreg, regdst}
    localparam logic [9:0] E_NONE = 10'h000;
    localparam logic [9:0] E_PCW  = 10'h200;
    localparam logic [9:0] E_IRW  = 10'h100;
    localparam logic [9:0] E_RGW  = 10'h080;
    localparam logic [9:0] E_MW   = 10'h040;
    localparam logic [9:0] E_BR   = 10'h020;
    localparam logic [9:0] E_BN   = 10'h010;
    localparam logic [9:0] E_ILL  = 10'h008;
    localparam logic [9:0] E_IORD = 10'h004;
    localparam logic [9:0] E_M2R  = 10'h002;
    localparam logic [9:0] E_RDST = 10'h001;

    logic [9:0] en0, en1, obs_en;
    logic [6:0] mx0, mx1, obs_mx;
    assign en0 = {bus0.pcwrite, bus0.irwrite, bus0.regwrite, bus0.memwrite, bus0.branch,
                  bus0.branch_ne, bus0.illegal, bus0.iord, bus0.memtoreg, bus0.regdst};
    assign en1 = {bus1.pcwrite, bus1.irwrite, bus1.regwrite, bus1.memwrite, bus1.branch,
                  bus1.branch_ne, bus1.illegal, bus1.iord, bus1.memtoreg, bus1.regdst};
    assign mx0 = {bus0.alusrca, bus0.alusrcb, bus0.pcsrc, bus0.aluop};
    assign mx1 = {bus1.alusrca, bus1.alusrcb, bus1.pcsrc, bus1.aluop};
    assign obs_en = sel ? en1 : en0;
    assign obs_mx = sel ? mx1 : mx0;

    typedef enum {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_ANDI, K_J, K_ILL} kind_t;

    typedef struct {
        logic       rnd;
        logic       mr;
        logic [9:0] en;
        logic [6:0] mx;
        logic       dop;
    } cyc_t;

    cyc_t sched[$];

    function automatic logic [6:0] mx(input logic a, input logic [1:0] b,
                                      input logic [1:0] p, input logic [1:0] o);
        return {a, b, p, o};
    endfunction

    function automatic cyc_t c(input logic rnd, input logic mr, input logic [9:0] en,
                               input logic [6:0] m, input logic dop);
        cyc_t r;
        r.rnd = rnd; r.mr = mr; r.en = en; r.mx = m; r.dop = dop;
        return r;
    endfunction

    function automatic kind_t classify(input logic [5:0] o, input bit ebne, input bit eandi);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b000101: return ebne ? K_BNE : K_ILL;
            6'b001000: return K_ADDI;
            6'b001100: return eandi ? K_ANDI : K_ILL;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [8];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                6'b000101, 6'b001000, 6'b001100, 6'b000010};
        if ($urandom_range(0, 3) == 0) return 6'($urandom);
        return ops[$urandom_range(0, 7)];
    endfunction

    // Every instruction: FETCH (plus waits), DECODE, then its class-specific tail.
    task automatic build(input logic [5:0] o, input int wf, input int wm, input bit en_opt);
        kind_t k;
        k = classify(o, en_opt, en_opt);
        sched.delete();
        for (int i = 0; i < wf; i++)
            sched.push_back(c(1'b0, 1'b0, E_NONE, mx(1'b0, 2'd1, 2'd0, 2'd0), 1'b0));
        sched.push_back(c(1'b0, 1'b1, E_PCW | E_IRW, mx(1'b0, 2'd1, 2'd0, 2'd0), 1'b0));
        sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b0, 2'd3, 2'd0, 2'd0), 1'b1));
        case (k)
            K_LW: begin
                sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b1, 2'd2, 2'd0, 2'd0), 1'b0));
                for (int i = 0; i < wm; i++)
                    sched.push_back(c(1'b0, 1'b0, E_IORD, 7'd0, 1'b0));
                sched.push_back(c(1'b0, 1'b1, E_IORD, 7'd0, 1'b0));
                sched.push_back(c(1'b1, 1'b0, E_RGW | E_M2R, 7'd0, 1'b0));
            end
            K_SW: begin
                sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b1, 2'd2, 2'd0, 2'd0), 1'b0));
                for (int i = 0; i < wm; i++)
                    sched.push_back(c(1'b0, 1'b0, E_IORD | E_MW, 7'd0, 1'b0));
                sched.push_back(c(1'b0, 1'b1, E_IORD | E_MW, 7'd0, 1'b0));
            end
            K_R: begin
                sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b1, 2'd0, 2'd0, 2'd2), 1'b0));
                sched.push_back(c(1'b1, 1'b0, E_RGW | E_RDST, 7'd0, 1'b0));
            end
            K_BEQ:  sched.push_back(c(1'b1, 1'b0, E_BR, mx(1'b1, 2'd0, 2'd1, 2'd1), 1'b0));
            K_BNE:  sched.push_back(c(1'b1, 1'b0, E_BN, mx(1'b1, 2'd0, 2'd1, 2'd1), 1'b0));
            K_ADDI: begin
                sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b1, 2'd2, 2'd0, 2'd0), 1'b0));
                sched.push_back(c(1'b1, 1'b0, E_RGW, 7'd0, 1'b0));
            end
            K_ANDI: begin
                sched.push_back(c(1'b1, 1'b0, E_NONE, mx(1'b1, 2'd2, 2'd0, 2'd3), 1'b0));
                sched.push_back(c(1'b1, 1'b0, E_RGW, 7'd0, 1'b0));
            end
            K_J:    sched.push_back(c(1'b1, 1'b0, E_PCW, mx(1'b0, 2'd0, 2'd2, 2'd0), 1'b0));
            default: sched.push_back(c(1'b1, 1'b0, E_ILL, 7'd0, 1'b0));
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [5:0] o, input int wf, input int wm, input int abort_at);
        build(o, wf, wm, (sel == 1'b0));
        foreach (sched[i]) begin
            @(negedge clk);
            reset  = 1'b0;
            drv_mr = sched[i].rnd ? 1'($urandom_range(0, 1)) : sched[i].mr;
            drv_op = sched[i].dop ? o : 6'($urandom);
            #1;
            chk($sformatf("en dut%0d op=%b cyc=%0d", sel, o, i), 16'(obs_en), 16'(sched[i].en));
            chk($sformatf("mux dut%0d op=%b cyc=%0d", sel, o, i), 16'(obs_mx), 16'(sched[i].mx));
            if (i == abort_at) begin
                #2 reset = 1'b1;
                #1;
                chk($sformatf("async_reset_en op=%b cyc=%0d", o, i), 16'(obs_en), 16'(E_NONE));
                return;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        drv_mr = 1'b1;
        drv_op = 6'd0;
        sel    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_en", 16'(obs_en), 16'(E_NONE));
        chk("reset_mux", 16'(obs_mx), 16'(mx(1'b0, 2'd1, 2'd0, 2'd0)));

        run(OP_LW, 0, 2, -1);
        run(OP_SW, 0, 3, -1);
        run(OP_BNE, 0, 0, -1);
        run(OP_RTYPE, 0, 0, -1);
        run(OP_ANDI, 0, 0, -1);
        run(OP_J, 0, 0, -1);
        run(OP_BEQ, 1, 0, -1);
        run(OP_ADDI, 2, 0, -1);
        run(6'b111111, 0, 0, -1);
        repeat (40) run(rand_op(), $urandom_range(0, 2), $urandom_range(0, 3), -1);

        run(OP_SW, 0, 3, 3);
        run(OP_J, 0, 0, -1);
        run(OP_LW, 0, 0, -1);

        sel   = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_en dut1", 16'(obs_en), 16'(E_NONE));
        run(OP_BNE, 0, 0, -1);
        run(OP_ANDI, 0, 0, -1);
        run(OP_BEQ, 0, 0, -1);
        repeat (20) run(rand_op(), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        run(OP_LW, 1, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
